// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR, one log2 barrel stage per clock.
// Latency SHAMT_W+1 cycles from start to done; start is ignored while an operation is in flight.
module seq_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [5:0] OP_SLL = 6'b000000;
    localparam logic [5:0] OP_ROR = 6'b000001;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_work;
    logic [SHAMT_W-1:0]   r_shamt;
    logic [5:0]           r_op;
    logic [SHAMT_W-1:0]   r_k;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_dout;

    logic [SHAMT_W-1:0]   w_dist;
    logic [2*WIDTH-1:0]   w_ext_sra;
    logic [2*WIDTH-1:0]   w_ext_ror;
    logic [WIDTH-1:0]     w_stage;
    logic [WIDTH-1:0]     w_work_nxt;
    logic                 w_last;
    logic                 w_op_ok;
    logic                 w_unused_b;

    // Only the low SHAMT_W bits of the amount are meaningful.
    assign w_unused_b = ^dataB[WIDTH-1:SHAMT_W];

    assign w_dist    = {{(SHAMT_W-1){1'b0}}, 1'b1} << r_k;
    // The work MSB stays equal to the captured operand MSB under arithmetic fill.
    assign w_ext_sra = {{WIDTH{r_work[WIDTH-1]}}, r_work} >> w_dist;
    assign w_ext_ror = {r_work, r_work} >> w_dist;
    assign w_last    = (r_k == SHAMT_W'(SHAMT_W-1));
    assign w_op_ok   = (r_op == OP_SLL) || (r_op == OP_SRL) ||
                       (r_op == OP_SRA) || (r_op == OP_ROR);

    always_comb begin
        w_stage = r_work;
        case (r_op)
            OP_SLL:  w_stage = r_work << w_dist;
            OP_SRL:  w_stage = r_work >> w_dist;
            OP_SRA:  w_stage = w_ext_sra[WIDTH-1:0];
            OP_ROR:  w_stage = w_ext_ror[WIDTH-1:0];
            default: w_stage = r_work;
        endcase
        w_work_nxt = r_shamt[r_k] ? w_stage : r_work;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_shamt <= '0;
            r_op    <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_SHIFT);
            r_done  <= (w_state_nxt == S_DONE);
            if (r_state == S_IDLE && start) begin
                r_work  <= dataA;
                r_shamt <= dataB[SHAMT_W-1:0];
                r_op    <= Signal;
                r_k     <= '0;
            end else if (r_state == S_SHIFT) begin
                r_work <= w_work_nxt;
                r_k    <= r_k + 1'b1;
                if (w_last)
                    r_dout <= w_op_ok ? w_work_nxt : '0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign dataOut = r_dout;
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: 32-bit table + scoreboard, handshake/reset corners, and an 8-bit instance.
module tb_seq_shifter;
    localparam logic [5:0] SLL = 6'b000000;
    localparam logic [5:0] ROR = 6'b000001;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SRA = 6'b000011;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start8;
    logic [5:0]  sig, sig8;
    logic [31:0] dA, dB, dout;
    logic [7:0]  dA8, dB8, dout8;
    logic        busy, done, busy8, done8;

    int cyc = 0;
    int n_vec = 0;
    int n_fail = 0;
    int n_done = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [31:0] exp;
        int          cyc0;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    seq_shifter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Signal(sig),
        .dataA(dA), .dataB(dB), .busy(busy), .done(done), .dataOut(dout)
    );

    seq_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .Signal(sig8),
        .dataA(dA8), .dataB(dB8), .busy(busy8), .done(done8), .dataOut(dout8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy && done) check("busy_and_done", 32'd1, 32'd0);
            if (busy) begin
                busy_cnt++;
            end else if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("result", dout, e.exp);
                    check("latency", 32'(cyc - e.cyc0), 32'd6);
                    check("busy_cycles", 32'(busy_cnt), 32'd5);
                end
                busy_cnt = 0;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_done();
        int n0;
        n0 = n_done;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (n_done != n0) return;
        end
        check("done_timeout", 32'd1, 32'd0);
        sb.delete();
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        @(negedge clk);
        start = 1'b1; sig = op; dA = a; dB = b;
        sb.push_back('{exp, cyc});
        @(negedge clk);
        // Scramble inputs once captured; they must not influence the result.
        start = 1'b0; sig = 6'($urandom); dA = $urandom; dB = $urandom;
        wait_done();
    endtask

    task automatic run8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input string name);
        int n;
        @(negedge clk);
        start8 = 1'b1; sig8 = op; dA8 = a; dB8 = b;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start8 = 1'b0; dA8 = 8'($urandom); dB8 = 8'($urandom);
            end
            if (done8) begin
                n = i;
                break;
            end
        end
        check({name, "_latency"}, 32'(n), 32'd4);
        check({name, "_result"}, {24'd0, dout8}, {24'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        int n0;
        vecs[0]  = '{SRL, 32'h8000_0000, 32'd4,         32'h0800_0000};
        vecs[1]  = '{SRA, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF};
        vecs[2]  = '{SLL, 32'h0000_0001, 32'd31,        32'h8000_0000};
        vecs[3]  = '{SRL, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF};
        vecs[4]  = '{ROR, 32'h1234_5678, 32'd8,         32'h7812_3456};
        vecs[5]  = '{ROR, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678};
        vecs[6]  = '{SLL, 32'h0000_00F1, 32'hFFFF_FFE3, 32'h0000_0788};
        vecs[7]  = '{6'b111111, 32'hDEAD_BEEF, 32'd5,   32'h0000_0000};
        vecs[8]  = '{SRA, 32'h7FFF_0000, 32'd16,        32'h0000_7FFF};
        vecs[9]  = '{SRA, 32'hF000_0000, 32'd4,         32'hFF00_0000};
        vecs[10] = '{ROR, 32'h0000_0001, 32'd1,         32'h8000_0000};
        vecs[11] = '{SLL, 32'hFFFF_FFFF, 32'd16,        32'hFFFF_0000};

        reset = 1'b1; start = 1'b0; start8 = 1'b0;
        sig = '0; dA = '0; dB = '0; sig8 = '0; dA8 = '0; dB8 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_dout", dout, 32'd0);
        check("reset_dout8", {24'd0, dout8}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Second request held high through SHIFT and DONE must be dropped.
        @(negedge clk);
        n0 = n_done;
        start = 1'b1; sig = SRL; dA = 32'hF000_0000; dB = 32'd4;
        sb.push_back('{32'h0F00_0000, cyc});
        @(negedge clk);
        sig = SLL; dA = 32'd1; dB = 32'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (n_done != n0) break;
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("hs_one_done", 32'(n_done - n0), 32'd1);
        check("hs_dout_held", dout, 32'h0F00_0000);
        check("hs_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during the third SHIFT cycle aborts with no done pulse.
        n0 = n_done;
        @(negedge clk);
        start = 1'b1; sig = SRL; dA = 32'hFFFF_0000; dB = 32'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        check("abort_dout_held", dout, 32'h0F00_0000);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_dout", dout, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(n_done - n0), 32'd0);

        run8(SRA, 8'h90, 8'd3, 8'hF2, "w8_sra");
        run8(ROR, 8'h81, 8'd1, 8'hC0, "w8_ror");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
